simon_round_ctrl: RTL and testbench

Round sequencer for the memory game. It generates the pseudo-random colour sequence, plays it on the LEDs, checks the player's key entries against it, and grows the round length. At game end it presents the completed-round count on `sequence_counter` and issues the `load_current`/`load_best` strobes consumed by the high-score block.

---
 rtl/simon_round_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_simon_round_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/simon_round_ctrl.sv
// Round sequencer for the memory game: LFSR colour sequence, LED playback,
// key checking against the sequence, and end-of-game strobes for the high-score block.
module simon_round_ctrl #(
    parameter int MAX_LEN        = 15,
    parameter int SHOW_CYCLES    = 25_000_000,
    parameter int GAP_CYCLES     = 12_500_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       key_valid,
    input  logic [1:0] key,
    output logic [3:0] led,
    output logic [3:0] sequence_counter,
    output logic       load_current,
    output logic       load_best,
    output logic       busy,
    output logic       awaiting_input,
    output logic       game_over,
    output logic       won
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_INPUT,
        S_ROUND_OK,
        S_OVER
    } state_t;

    localparam logic [27:0] LP_SHOW = 28'(SHOW_CYCLES - 1);
    localparam logic [27:0] LP_GAP  = 28'(GAP_CYCLES - 1);
    localparam logic [27:0] LP_TMO  = 28'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LP_MAX  = 4'(MAX_LEN);

    function automatic logic [7:0] f_shift(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_lfsr, w_lfsr_nxt;
    logic [7:0]  r_seed, w_seed_nxt;
    logic [7:0]  r_cnt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic [3:0]  r_len, w_len_nxt;
    logic [27:0] r_timer, w_timer_nxt;
    logic [3:0]  r_sc, w_sc_nxt;
    logic        r_go, w_go_nxt;
    logic        r_won, w_won_nxt;
    logic        w_last;
    logic        w_tzero;

    assign w_last  = (r_idx == r_len - 4'd1);
    assign w_tzero = (r_timer == 28'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_seed_nxt  = r_seed;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_timer_nxt = r_timer;
        w_sc_nxt    = r_sc;
        w_go_nxt    = r_go;
        w_won_nxt   = r_won;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sc_nxt    = 4'd0;
                    w_len_nxt   = 4'd1;
                    w_go_nxt    = 1'b0;
                    w_won_nxt   = 1'b0;
                    // an all-zero seed would lock the LFSR
                    w_seed_nxt  = (r_cnt == 8'd0) ? 8'hA5 : r_cnt;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_lfsr_nxt  = f_shift(r_seed);
                w_idx_nxt   = 4'd0;
                w_timer_nxt = LP_SHOW;
                w_state_nxt = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (w_tzero) begin
                    w_timer_nxt = LP_GAP;
                    w_state_nxt = S_SHOW_OFF;
                end else begin
                    w_timer_nxt = r_timer - 28'd1;
                end
            end
            S_SHOW_OFF: begin
                if (!w_tzero) begin
                    w_timer_nxt = r_timer - 28'd1;
                end else if (w_last) begin
                    w_lfsr_nxt  = f_shift(r_seed);
                    w_idx_nxt   = 4'd0;
                    w_timer_nxt = LP_TMO;
                    w_state_nxt = S_INPUT;
                end else begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_lfsr_nxt  = f_shift(r_lfsr);
                    w_timer_nxt = LP_SHOW;
                    w_state_nxt = S_SHOW_ON;
                end
            end
            S_INPUT: begin
                // a key in the expiry cycle wins over the timeout
                if (key_valid) begin
                    if (key != r_lfsr[1:0]) begin
                        w_state_nxt = S_OVER;
                    end else if (w_last) begin
                        w_state_nxt = S_ROUND_OK;
                    end else begin
                        w_idx_nxt   = r_idx + 4'd1;
                        w_lfsr_nxt  = f_shift(r_lfsr);
                        w_timer_nxt = LP_TMO;
                    end
                end else if (w_tzero) begin
                    w_state_nxt = S_OVER;
                end else begin
                    w_timer_nxt = r_timer - 28'd1;
                end
            end
            S_ROUND_OK: begin
                w_sc_nxt = r_len;
                if (r_len == LP_MAX) begin
                    w_won_nxt   = 1'b1;
                    w_state_nxt = S_OVER;
                end else begin
                    w_len_nxt   = r_len + 4'd1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_OVER: begin
                w_go_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_lfsr  <= 8'd0;
            r_seed  <= 8'd0;
            r_cnt   <= 8'd0;
            r_idx   <= 4'd0;
            r_len   <= 4'd1;
            r_timer <= 28'd0;
            r_sc    <= 4'd0;
            r_go    <= 1'b0;
            r_won   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_seed  <= w_seed_nxt;
            r_cnt   <= r_cnt + 8'd1;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_timer <= w_timer_nxt;
            r_sc    <= w_sc_nxt;
            r_go    <= w_go_nxt;
            r_won   <= w_won_nxt;
        end
    end

    assign led              = (r_state == S_SHOW_ON) ? (4'b0001 << r_lfsr[1:0]) : 4'd0;
    assign sequence_counter = r_sc;
    assign load_current     = (r_state == S_OVER);
    assign load_best        = (r_state == S_OVER);
    assign busy             = (r_state != S_IDLE);
    assign awaiting_input   = (r_state == S_INPUT);
    assign game_over        = r_go;
    assign won              = r_won;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: two instances (MAX_LEN 15 and 2) with short timers,
// game table plus hand sequences for reset, noise and key-at-expiry cases.
module tb_simon_round_ctrl;

    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 20;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start_v [2];
    logic       kv_v    [2];
    logic [1:0] key_v   [2];
    logic [3:0] led_v   [2];
    logic [3:0] sc_v    [2];
    logic       lc_v    [2];
    logic       lb_v    [2];
    logic       busy_v  [2];
    logic       aw_v    [2];
    logic       go_v    [2];
    logic       won_v   [2];

    int total = 0;
    int bad   = 0;
    int strb  [2];
    logic [7:0] cnt;
    logic [1:0] exp_q [$];

    always #5 clk = ~clk;

    simon_round_ctrl #(
        .MAX_LEN(15), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) u0 (
        .clk(clk), .resetn(resetn), .start(start_v[0]), .key_valid(kv_v[0]),
        .key(key_v[0]), .led(led_v[0]), .sequence_counter(sc_v[0]),
        .load_current(lc_v[0]), .load_best(lb_v[0]), .busy(busy_v[0]),
        .awaiting_input(aw_v[0]), .game_over(go_v[0]), .won(won_v[0])
    );

    simon_round_ctrl #(
        .MAX_LEN(2), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) u1 (
        .clk(clk), .resetn(resetn), .start(start_v[1]), .key_valid(kv_v[1]),
        .key(key_v[1]), .led(led_v[1]), .sequence_counter(sc_v[1]),
        .load_current(lc_v[1]), .load_best(lb_v[1]), .busy(busy_v[1]),
        .awaiting_input(aw_v[1]), .game_over(go_v[1]), .won(won_v[1])
    );

    // reference seed counter: free-running, cleared by reset
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= 8'd0;
        else         cnt <= cnt + 8'd1;
    end

    always @(negedge clk) begin
        if (lc_v[0]) strb[0]++;
        if (lc_v[1]) strb[1]++;
    end

    typedef struct {
        int         d;
        int         n_ok;
        int         mode;   // 0 wrong key, 1 timeout, 2 play to win
        int         dly;
        bit         noise;
        logic [3:0] exp_sc;
        bit         exp_won;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [7:0] shf(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [1:0] elem(input logic [7:0] s, input int i);
        logic [7:0] q;
        q = shf(s);
        for (int k = 0; k < i; k++) q = shf(q);
        return q[1:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int d, input string nm, input logic [3:0] l,
                        input logic aw, input logic bz, input logic sb);
        @(negedge clk);
        chk(nm, {24'd0, led_v[d], aw_v[d], busy_v[d], lc_v[d], lb_v[d]},
                {24'd0, l, aw, bz, sb, sb});
    endtask

    function automatic logic [31:0] all_out(input int d);
        return {18'd0, led_v[d], sc_v[d], lc_v[d], lb_v[d],
                busy_v[d], aw_v[d], go_v[d], won_v[d]};
    endfunction

    task automatic play(input vec_t v);
        int d, maxl, base, len;
        logic [7:0] sd;
        logic [1:0] e;
        bit done, fail;
        d    = v.d;
        maxl = (d == 0) ? 15 : 2;
        base = strb[d];
        done = 1'b0;
        chk("idle_busy", 32'(busy_v[d]), 32'd0);
        sd = (cnt == 8'd0) ? 8'hA5 : cnt;
        start_v[d] = 1'b1;
        step(d, "load", 4'd0, 1'b0, 1'b1, 1'b0);
        start_v[d] = 1'b0;
        chk("sc_clear", 32'(sc_v[d]), 32'd0);
        len = 0;
        while (!done) begin
            len++;
            for (int i = 0; i < len; i++) exp_q.push_back(elem(sd, i));
            for (int i = 0; i < len; i++) begin
                e = exp_q.pop_front();
                for (int c = 0; c < SHOW; c++) begin
                    step(d, "show_on", 4'b0001 << e, 1'b0, 1'b1, 1'b0);
                    kv_v[d]    = 1'b0;
                    start_v[d] = 1'b0;
                    if (v.noise && len == 1 && i == 0 && c == 0) begin
                        kv_v[d]    = 1'b1;
                        key_v[d]   = ~e;
                        start_v[d] = 1'b1;
                    end
                end
                for (int c = 0; c < GAP; c++)
                    step(d, "show_off", 4'd0, 1'b0, 1'b1, 1'b0);
            end
            fail = (v.mode != 2) && (len == v.n_ok + 1);
            if (fail && v.mode == 1) begin
                for (int c = 0; c < TMO; c++)
                    step(d, "timeout_wait", 4'd0, 1'b1, 1'b1, 1'b0);
                step(d, "over_timeout", 4'd0, 1'b0, 1'b1, 1'b1);
                chk("sc_over", 32'(sc_v[d]), 32'(v.exp_sc));
                done = 1'b1;
            end else begin
                for (int i = 0; i < len && !done; i++) begin
                    for (int c = 0; c <= v.dly; c++) begin
                        step(d, "input", 4'd0, 1'b1, 1'b1, 1'b0);
                        kv_v[d] = 1'b0;
                    end
                    e = elem(sd, i);
                    kv_v[d]  = 1'b1;
                    key_v[d] = fail ? ~e : e;
                    if (fail) begin
                        step(d, "over_wrong", 4'd0, 1'b0, 1'b1, 1'b1);
                        kv_v[d] = 1'b0;
                        chk("sc_over", 32'(sc_v[d]), 32'(v.exp_sc));
                        done = 1'b1;
                    end else if (i == len - 1) begin
                        step(d, "round_ok", 4'd0, 1'b0, 1'b1, 1'b0);
                        kv_v[d] = 1'b0;
                        if (len == maxl) begin
                            step(d, "over_win", 4'd0, 1'b0, 1'b1, 1'b1);
                            chk("sc_win", 32'(sc_v[d]), 32'(len));
                            chk("won_in_over", 32'(won_v[d]), 32'd1);
                            done = 1'b1;
                        end else begin
                            step(d, "load", 4'd0, 1'b0, 1'b1, 1'b0);
                            chk("sc_round", 32'(sc_v[d]), 32'(len));
                        end
                    end
                end
            end
        end
        step(d, "idle", 4'd0, 1'b0, 1'b0, 1'b0);
        chk("game_over", 32'(go_v[d]), 32'd1);
        chk("won", 32'(won_v[d]), 32'(v.exp_won));
        chk("sc_final", 32'(sc_v[d]), 32'(v.exp_sc));
        chk("strobe_count", 32'(strb[d] - base), 32'd1);
    endtask

    task automatic reset_mid();
        logic [7:0] sd;
        int base;
        base = strb[0];
        sd   = (cnt == 8'd0) ? 8'hA5 : cnt;
        start_v[0] = 1'b1;
        step(0, "rst_load", 4'd0, 1'b0, 1'b1, 1'b0);
        start_v[0] = 1'b0;
        step(0, "rst_show", 4'b0001 << elem(sd, 0), 1'b0, 1'b1, 1'b0);
        resetn = 1'b0;
        #1;
        chk("reset_async", all_out(0), 32'd0);
        @(negedge clk);
        chk("reset_next", all_out(0), 32'd0);
        chk("reset_no_strobe", 32'(strb[0] - base), 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        vecs[0] = '{d: 0, n_ok: 3, mode: 0, dly: 0,  noise: 1'b0, exp_sc: 4'd3, exp_won: 1'b0};
        vecs[1] = '{d: 0, n_ok: 0, mode: 1, dly: 0,  noise: 1'b0, exp_sc: 4'd0, exp_won: 1'b0};
        vecs[2] = '{d: 1, n_ok: 2, mode: 2, dly: 0,  noise: 1'b0, exp_sc: 4'd2, exp_won: 1'b1};
        vecs[3] = '{d: 0, n_ok: 1, mode: 0, dly: 19, noise: 1'b0, exp_sc: 4'd1, exp_won: 1'b0};
        vecs[4] = '{d: 0, n_ok: 2, mode: 0, dly: 0,  noise: 1'b1, exp_sc: 4'd2, exp_won: 1'b0};
        strb[0] = 0;
        strb[1] = 0;
        resetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            kv_v[d]    = 1'b0;
            key_v[d]   = 2'd0;
        end
        repeat (2) @(negedge clk);
        chk("reset_u0", all_out(0), 32'd0);
        chk("reset_u1", all_out(1), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) play(vecs[i]);
        reset_mid();
        play(vecs[1]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
